adder_result_serializer: RTL
============================

ADDER_RESULT_SERIALIZER -- requirements
Module: adder_result_serializer

Interface
REQ-001 The module SHALL have no parameters; all lane data is 32 bits and there are 4 lanes.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd  input  3  adder_array command that produced the results: 0-3 selects single lane 0-3, 4-7 selects all four lanes.
REQ-005 in_valid  input  1  dout0-3, overflow and cmd are valid this cycle.
REQ-006 in_ready  output  1  block can accept a result set.
REQ-007 dout0, dout1, dout2, dout3  input  32 each  adder_array lane results.
REQ-008 overflow  input  4  adder_array per-lane overflow, bit n = lane n.
REQ-009 out_valid  output  1  out_data, out_lane, out_ovf and out_last are valid.
REQ-010 out_ready  input  1  downstream accepts the current word.
REQ-011 out_data  output  32  serialized lane result.
REQ-012 out_lane  output  2  lane index of out_data.
REQ-013 out_ovf  output  1  overflow bit of that lane.
REQ-014 out_last  output  1  final word of the current result set.
REQ-015 word_count  output  16  count of words transferred out, wrapping 0xFFFF->0x0000.
REQ-016 ovf_sticky  output  4  sticky per-lane overflow status (see Configuration).
REQ-017 ovf_clr  input  1  clears ovf_sticky.

Function
REQ-018 Two states SHALL exist: IDLE (in_ready=1, out_valid=0) and SEND (in_ready=0, out_valid=1).
REQ-019 In IDLE, in_valid=1 SHALL register dout0-3, overflow and cmd in one edge and enter SEND next cycle; in_valid while in SEND is ignored.
REQ-020 Lane sequence: cmd 0-3 emits only lane cmd; cmd 4-7 emits lanes 0,1,2,3 in ascending order.
REQ-021 In SEND, out_data/out_lane/out_ovf SHALL reflect the current lane from the registered copy and stay stable while out_ready=0.
REQ-022 out_last SHALL be 1 exactly on the final word of the set (the only word for single-lane, lane 3 for all-lanes).
REQ-023 A transfer occurs when out_valid and out_ready are both 1; it advances to the next lane, or returns to IDLE if out_last=1.
REQ-024 Input-accept to first out_valid latency SHALL be 1 cycle; back-to-back sets SHALL have exactly one IDLE cycle between last transfer and next accept.
REQ-025 word_count SHALL increment by 1 on every transfer and wrap modulo 2^16.
REQ-026 Registered data SHALL not change while in SEND, regardless of changes on dout0-3, overflow or cmd.

Reset
REQ-027 rst=1 SHALL force IDLE, out_valid=0, in_ready=1 on the following cycle, out_data=0, out_lane=0, out_ovf=0, out_last=0, word_count=0, ovf_sticky=0.
REQ-028 rst asserted mid-SEND SHALL abandon the set; no further words of it are emitted and word_count is not incremented for that cycle.
REQ-029 rst SHALL take priority over in_valid, out_ready and ovf_clr in the same cycle.

Configuration
REQ-030 Macro STICKY_OVF_EN defined: ovf_sticky bit n SHALL set on any transfer with out_lane=n and out_ovf=1, and clear on ovf_clr=1; set wins over clear in the same cycle.
REQ-031 Macro STICKY_OVF_EN undefined: ovf_sticky SHALL be constant 0, ovf_clr ignored, ports retained.

Verification
REQ-032 cmd=2, dout2=0x0000_0010, overflow=4'b0100, out_ready=1 -> one word: out_data=0x10, out_lane=2, out_ovf=1, out_last=1; word_count=1.
REQ-033 cmd=4, dout0-3=0x11,0x22,0x33,0x44, overflow=0, out_ready=1 -> four consecutive words lanes 0-3, out_last only on 0x44, word_count=4.
REQ-034 cmd=4, out_ready toggled 0/1 every cycle, dout inputs changed during SEND -> original 4 words emitted unchanged, each held while out_ready=0.
REQ-035 rst pulsed after second word of a cmd=4 set -> out_valid=0 next cycle, word_count=0, in_ready=1, remaining words never appear.
REQ-036 With STICKY_OVF_EN, cmd=4, overflow=4'b1001 -> ovf_sticky=4'b1001 after set; ovf_clr pulse -> 4'b0000; without macro -> ovf_sticky stays 4'b0000.
REQ-037 Preload 0xFFFE transfers then cmd=4 set -> word_count reads 0xFFFF, 0x0000, 0x0001, 0x0002.

Source files
------------

// File: rtl/adder_result_serializer.sv
// Serializes one adder_array result set (single lane or all four lanes) into a
// valid/ready word stream. Optional sticky overflow tracking via STICKY_OVF_EN.
module adder_result_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  cmd,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dout0,
    input  logic [31:0] dout1,
    input  logic [31:0] dout2,
    input  logic [31:0] dout3,
    input  logic [3:0]  overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_lane,
    output logic        out_ovf,
    output logic        out_last,
    output logic [15:0] word_count,
    output logic [3:0]  ovf_sticky,
    input  logic        ovf_clr
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0][31:0]  data_q, data_d;
    logic [3:0]        ovf_q, ovf_d;
    logic              all_q, all_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       word_count_q, word_count_d;
    logic [3:0]        sticky_q, sticky_d;

    logic send;
    logic last;
    logic xfer;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        ovf_d        = ovf_q;
        all_d        = all_q;
        lane_d       = lane_q;
        word_count_d = word_count_q;

        send = (state_q == ST_SEND);
        last = send && (!all_q || (lane_q == 2'd3));
        xfer = send && out_ready;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = {dout3, dout2, dout1, dout0};
                    ovf_d   = overflow;
                    all_d   = cmd[2];
                    lane_d  = cmd[2] ? 2'd0 : cmd[1:0];
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (last) begin
                        state_d = ST_IDLE;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (xfer) begin
            word_count_d = word_count_q + 16'd1;
        end
    end

`ifdef STICKY_OVF_EN
    // Clear first so that a same-cycle set overrides the clear.
    always_comb begin
        sticky_d = sticky_q;
        if (ovf_clr) begin
            sticky_d = 4'b0000;
        end
        if (xfer && ovf_q[lane_q]) begin
            sticky_d = sticky_d | (4'b0001 << lane_q);
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;

    always_comb begin
        sticky_d = 4'b0000;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            ovf_q        <= 4'b0000;
            all_q        <= 1'b0;
            lane_q       <= 2'd0;
            word_count_q <= 16'd0;
            sticky_q     <= 4'b0000;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            ovf_q        <= ovf_d;
            all_q        <= all_d;
            lane_q       <= lane_d;
            word_count_q <= word_count_d;
            sticky_q     <= sticky_d;
        end
    end

    // Word outputs are forced to zero outside SEND so idle/reset reads are clean.
    assign in_ready   = !send;
    assign out_valid  = send;
    assign out_data   = send ? data_q[lane_q] : 32'd0;
    assign out_lane   = send ? lane_q : 2'd0;
    assign out_ovf    = send ? ovf_q[lane_q] : 1'b0;
    assign out_last   = last;
    assign word_count = word_count_q;
    assign ovf_sticky = sticky_q;

endmodule
